// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 UART receiver with error-tagged FIFO; UART_RX_MONITOR_PARITY_EN adds even parity
`timescale 1ns/1ps
module uart_rx_monitor #(
  parameter int DIVISOR    = 69,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  input  logic                          clear_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [7:0]                    data_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o
);

  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef UART_RX_MONITOR_PARITY_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_MONITOR_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t r_state, w_next;

  logic          r_rx_meta, r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_data;
  logic          w_tick;
  logic          w_load, w_clr_idx, w_shift, w_push;
  logic [CW-1:0] w_load_val;
  logic          w_frame_err;
  logic [EW-1:0] w_entry;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic          r_par;
  logic          w_samp_par;
  logic          w_par_err;
`endif

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [LW-1:0] r_wptr, r_rptr;
  logic          r_overflow;
  logic [LW-1:0] w_level;
  logic          w_full, w_empty, w_pop, w_wr;
  logic [EW-1:0] w_head;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!rx_en_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (!r_rx_s) w_next = ST_START;
        ST_START:  if (w_tick) w_next = r_rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_MONITOR_PARITY_EN
        ST_DATA:   if (w_tick && r_idx == 3'd7) w_next = ST_PARITY;
        ST_PARITY: if (w_tick) w_next = ST_STOP;
`else
        ST_DATA:   if (w_tick && r_idx == 3'd7) w_next = ST_STOP;
`endif
        ST_STOP:   if (w_tick) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_clr_idx  = 1'b0;
    w_shift    = 1'b0;
    w_push     = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
    w_samp_par = 1'b0;
`endif
    if (rx_en_i) begin
      case (r_state)
        ST_IDLE: if (!r_rx_s) begin
          w_load     = 1'b1;
          w_load_val = HALF_LOAD;
        end
        ST_START: if (w_tick && !r_rx_s) begin
          w_load     = 1'b1;
          w_load_val = FULL_LOAD;
          w_clr_idx  = 1'b1;
        end
        ST_DATA: if (w_tick) begin
          w_shift    = 1'b1;
          w_load     = 1'b1;
          w_load_val = FULL_LOAD;
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        ST_PARITY: if (w_tick) begin
          w_samp_par = 1'b1;
          w_load     = 1'b1;
          w_load_val = FULL_LOAD;
        end
`endif
        ST_STOP: if (w_tick) w_push = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_data <= '0;
`ifdef UART_RX_MONITOR_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else begin
      if (w_load)       r_cnt <= w_load_val;
      else if (!w_tick) r_cnt <= r_cnt - CW'(1);
      if (w_clr_idx) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_data[r_idx] <= r_rx_s;
        r_idx         <= r_idx + 3'd1;
      end
`ifdef UART_RX_MONITOR_PARITY_EN
      if (w_samp_par) r_par <= r_rx_s;
`endif
    end
  end

  assign w_frame_err = ~r_rx_s;
`ifdef UART_RX_MONITOR_PARITY_EN
  assign w_par_err = (^r_data) ^ r_par;
  assign w_entry   = {w_par_err, w_frame_err, r_data};
`else
  assign w_entry   = {w_frame_err, r_data};
`endif

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == LW'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = !w_empty && ready_i;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)            r_wptr     <= r_wptr + LW'(1);
      if (w_pop)           r_rptr     <= r_rptr + LW'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr && !clear_i) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign valid_o     = !w_empty;
  assign data_o      = valid_o ? w_head[7:0] : 8'h00;
  assign frame_err_o = valid_o & w_head[8];
`ifdef UART_RX_MONITOR_PARITY_EN
  assign parity_err_o = valid_o & w_head[9];
`else
  assign parity_err_o = 1'b0;
`endif
  assign overflow_o  = r_overflow;
  assign level_o     = w_level;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - randomized self-checking bench for uart_rx_monitor against a queue model
`timescale 1ns/1ps
module tb_uart_rx_monitor;
  localparam int DIV   = 69;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_MONITOR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk_in  = 1'b0;
  logic          reset   = 1'b1;
  logic          rx_i    = 1'b1;
  logic          rx_en_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [7:0]    data_o;
  logic          frame_err_o;
  logic          parity_err_o;
  logic          overflow_o;
  logic [LW-1:0] level_o;
  logic          busy_o;

  uart_rx_monitor #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx_i        (rx_i),
    .rx_en_i     (rx_en_i),
    .clear_i     (clear_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overflow_o  (overflow_o),
    .level_o     (level_o),
    .busy_o      (busy_o)
  );

  always #5 clk_in = ~clk_in;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  logic       prev_valid = 1'b0;
  bit         rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) tick();
  endtask

  // Model: every completed frame becomes one entry unless the FIFO already holds DEPTH.
  task automatic model_push(input logic [7:0] b, input logic ferr, input logic perr);
    if (exp_q.size() < DEPTH) exp_q.push_back({perr, ferr, b});
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    if (PAR) hold(par_ok ? ^b : ~^b, DIV);
    model_push(b, !stop_ok, PAR && !par_ok);
    hold(stop_ok, DIV);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while ((level_o != 0 || exp_q.size() != 0) && k < max_cycles) begin
      tick();
      k++;
    end
    chk("drain", (level_o == 0 && exp_q.size() == 0), 1);
  endtask

  always @(negedge clk_in) begin
    if (!reset && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pop", {24'h0, data_o}, 32'h1ff);
      end else begin
        exp_e = exp_q.pop_front();
        chk("pop_data", data_o, exp_e[7:0]);
        chk("pop_frame_err", frame_err_o, exp_e[8]);
        chk("pop_parity_err", parity_err_o, exp_e[9]);
      end
    end
    if (!valid_o && prev_valid) chk("empty_zero", {data_o, frame_err_o, parity_err_o}, 0);
    prev_valid = valid_o;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded time limit, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         s_ok, p_ok;
    int         gap;

    repeat (3) tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_frame", frame_err_o, 0);
    chk("rst_parity", parity_err_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_busy", busy_o, 0);
    reset = 1'b0;
    rx_en_i = 1'b1;
    ready_i = 1'b1;
    repeat (5) tick();

    send(8'h55, 1, 1);
    hold(1'b1, DIV);
    wait_drain(200);

    ready_i = 1'b0;
    send(8'hA5, 1, 1);
    send(8'h3C, 1, 1);
    hold(1'b1, 10);
    chk("b2b_level", level_o, 2);
    chk("b2b_head", data_o, 8'hA5);
    ready_i = 1'b1;
    tick();
    chk("b2b_level_after_pop1", level_o, 1);
    tick();
    chk("b2b_level_after_pop2", level_o, 0);

    send(8'h00, 0, 1);
    hold(1'b1, 2 * DIV);
    chk("ferr_busy_idle", busy_o, 0);
    send(8'h7E, 1, 1);
    hold(1'b1, DIV);
    wait_drain(200);

    ready_i = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      send(8'(i), 1, 1);
      hold(1'b1, 5);
    end
    chk("ovf_level", level_o, 16);
    chk("ovf_flag", overflow_o, 1);
    ready_i = 1'b1;
    wait_drain(100);
    chk("ovf_sticky", overflow_o, 1);
    ready_i = 1'b0;
    send(8'h11, 1, 1);
    send(8'h22, 1, 1);
    hold(1'b1, 5);
    chk("pre_clear_level", level_o, 2);
    clear_i = 1'b1;
    exp_q.delete();
    tick();
    clear_i = 1'b0;
    chk("clear_overflow", overflow_o, 0);
    chk("clear_level", level_o, 0);
    chk("clear_valid", valid_o, 0);
    ready_i = 1'b1;

    hold(1'b0, 20);
    hold(1'b1, 5);
    chk("glitch_busy", busy_o, 1);
    hold(1'b1, 60);
    chk("glitch_idle", busy_o, 0);
    chk("glitch_level", level_o, 0);

    hold(1'b0, DIV);
    hold(1'b1, 4 * DIV + DIV / 2);
    reset = 1'b1;
    repeat (3) tick();
    chk("abort_rst_valid", valid_o, 0);
    chk("abort_rst_data", data_o, 0);
    chk("abort_rst_level", level_o, 0);
    chk("abort_rst_busy", busy_o, 0);
    chk("abort_rst_overflow", overflow_o, 0);
    reset = 1'b0;
    hold(1'b1, 6 * DIV);
    send(8'h81, 1, 1);
    hold(1'b1, DIV);
    wait_drain(200);

    hold(1'b0, DIV);
    hold(1'b1, 4 * DIV + DIV / 2);
    rx_en_i = 1'b0;
    repeat (3) tick();
    chk("abort_en_busy", busy_o, 0);
    rx_en_i = 1'b1;
    hold(1'b1, 6 * DIV);
    chk("abort_en_level", level_o, 0);
    send(8'hC3, 1, 1);
    hold(1'b1, DIV);
    wait_drain(200);

`ifdef UART_RX_MONITOR_PARITY_EN
    send(8'h01, 1, 0);
    hold(1'b1, DIV);
    send(8'h03, 1, 1);
    hold(1'b1, DIV);
    wait_drain(200);
`endif

    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 7) != 0);
      p_ok = ($urandom_range(0, 5) != 0);
      send(b, s_ok, p_ok);
      gap = s_ok ? int'($urandom_range(0, 30)) : DIV + int'($urandom_range(0, 30));
      hold(1'b1, gap);
    end
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    hold(1'b1, DIV);
    wait_drain(500);
    chk("end_overflow", overflow_o, 0);
    chk("end_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
